// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and address check for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WAIT_CNT_W = 4;

  // Flags a word access that is misaligned or lies beyond the implemented depth.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - 2**ADDR_W x 32 storage, byte-masked synchronous write, registered read
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        wmask,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word load/store responder with wait states; DMEM_BYTE_EN_EN adds req_be
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]  req_be,
`endif
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [31:0]           cap_addr;
  logic [31:0]           cap_wdata;
  logic                  cap_we;
  logic                  rdata_ok;
  logic [31:0]           mem_rdata;

  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_we;
  logic [3:0]  cur_be;
  logic        cur_err;
  logic        go_resp;
  logic        mem_we;
  logic        mem_re;

`ifdef DMEM_BYTE_EN_EN
  logic [3:0] cap_be;

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_be <= 4'h0;
    end else if (state == IDLE && req_valid) begin
      cap_be <= req_be;
    end
  end

  assign cur_be = (state == IDLE) ? req_be : cap_be;
`else
  assign cur_be = 4'hF;
`endif

  // With zero wait states RESP is entered on the accepting edge, so the live
  // request must drive storage directly rather than the not-yet-captured copy.
  always_comb begin
    cur_addr  = (state == IDLE) ? req_addr  : cap_addr;
    cur_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    cur_we    = (state == IDLE) ? req_we    : cap_we;
    cur_err   = addr_err(cur_addr, ADDR_W);
    go_resp   = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                ((state == WAIT) && (wait_cnt == '0));
    mem_we    = go_resp && !reset && cur_we  && !cur_err;
    mem_re    = go_resp && !reset && !cur_we && !cur_err;
  end

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .wmask (cur_be),
    .waddr (cur_addr[ADDR_W+1:2]),
    .wdata (cur_wdata),
    .re    (mem_re),
    .raddr (cur_addr[ADDR_W+1:2]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata_ok   <= 1'b0;
      wait_cnt   <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_we    <= req_we;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= cur_err;
              rdata_ok   <= !cur_we && !cur_err;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= cur_err;
            rdata_ok   <= !cur_we && !cur_err;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          rdata_ok   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign resp_rdata = rdata_ok ? mem_rdata : 32'd0;

endmodule
